// File: rtl/l1_coh_pkg.sv
// Shared encodings for the L1 coherent cache: line states, controller states,
// message bit positions and address geometry.
package l1_coh_pkg;
    localparam int INDEX_W = 2;
    localparam int TAG_W   = 6;
    localparam int LINES   = 1 << INDEX_W;

    localparam int MSG_READ  = 2;
    localparam int MSG_INV   = 1;
    localparam int MSG_WRITE = 0;

    typedef enum logic [1:0] {LS_I = 2'b00, LS_S = 2'b01, LS_M = 2'b10} line_state_t;
    typedef enum logic [2:0] {ST_IDLE, ST_WB, ST_REQ, ST_WAIT, ST_FILL} fsm_state_t;
    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_UPG} req_op_t;
endpackage

// File: rtl/l1_line_store.sv
// Tag/state/data arrays. The snoop port sees the line as it will look after
// this cycle's fill, so a snoop on a line being written acts on the new contents.
module l1_line_store
    import l1_coh_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [INDEX_W-1:0] lk_index,
    output logic [TAG_W-1:0]   lk_tag,
    output line_state_t        lk_state,
    output logic [7:0]         lk_data,
    input  logic               wr_en,
    input  logic [TAG_W-1:0]   wr_tag,
    input  line_state_t        wr_state,
    input  logic [7:0]         wr_data,
    input  logic               clr_en,
    input  logic [INDEX_W-1:0] sn_index,
    output logic [TAG_W-1:0]   sn_tag,
    output line_state_t        sn_state,
    output logic [7:0]         sn_data,
    input  logic               sn_en,
    input  line_state_t        sn_new_state
);
    logic [TAG_W-1:0] tags   [LINES];
    line_state_t      states [LINES];
    logic [7:0]       datas  [LINES];
    logic             wr_hit;

    assign lk_tag   = tags[lk_index];
    assign lk_state = states[lk_index];
    assign lk_data  = datas[lk_index];

    assign wr_hit   = wr_en && (lk_index == sn_index);
    assign sn_tag   = wr_hit ? wr_tag   : tags[sn_index];
    assign sn_state = wr_hit ? wr_state : states[sn_index];
    assign sn_data  = wr_hit ? wr_data  : datas[sn_index];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LINES; i++) begin
                tags[i]   <= '0;
                states[i] <= LS_I;
                datas[i]  <= '0;
            end
        end else begin
            if (wr_en) begin
                tags[lk_index]   <= wr_tag;
                states[lk_index] <= wr_state;
                datas[lk_index]  <= wr_data;
            end else if (clr_en) begin
                states[lk_index] <= LS_I;
            end
            // Snoop lands last so it overrides a same-cycle fill.
            if (sn_en)
                states[sn_index] <= sn_new_state;
        end
    end
endmodule

// File: rtl/l1_coherent_cache.sv
// Direct-mapped MSI L1 controller: turns CPU loads/stores into directory
// messages and services directory invalidate/fetch snoops in every state.
module l1_coherent_cache
    import l1_coh_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_req_valid,
    input  logic       cpu_req_write,
    input  logic [7:0] cpu_req_addr,
    input  logic [7:0] cpu_req_wdata,
    output logic       cpu_ready,
    output logic       cpu_done,
    output logic [7:0] cpu_rdata,
    output logic [2:0] msg_out,
    output logic [7:0] msg_addr,
    output logic       wb_valid,
    output logic [7:0] wb_addr,
    output logic [7:0] wb_data,
    input  logic       dir_reply_valid,
    input  logic [7:0] dir_reply_data,
    input  logic       dir_invalidate,
    input  logic       dir_fetch,
    input  logic [7:0] dir_snoop_addr
);
    fsm_state_t         state;
    req_op_t            op, eff_op;
    logic [7:0]         req_addr, req_wdata, reply_data;
    logic               retry;

    logic [INDEX_W-1:0] lk_index;
    logic [TAG_W-1:0]   lk_tag, cur_tag, sn_tag;
    line_state_t        lk_state, sn_state, wr_state, sn_new_state;
    logic [7:0]         lk_data, sn_data, wr_data;
    logic               lk_hit, wr_en, clr_en, sn_en, sn_match;
    logic               snoop_inv, snoop_fetch, snoop_wb, fsm_wb, race_inv, upg_ok;

    assign lk_index = (state == ST_IDLE) ? cpu_req_addr[INDEX_W-1:0] : req_addr[INDEX_W-1:0];
    assign cur_tag  = (state == ST_IDLE) ? cpu_req_addr[7:INDEX_W]   : req_addr[7:INDEX_W];
    assign lk_hit   = (lk_state != LS_I) && (lk_tag == cur_tag);

    always_comb begin
        wr_en    = 1'b0;
        wr_state = LS_M;
        wr_data  = req_wdata;
        if (state == ST_IDLE && cpu_req_valid && cpu_req_write && lk_hit && lk_state == LS_M) begin
            wr_en   = 1'b1;
            wr_data = cpu_req_wdata;
        end else if (state == ST_FILL) begin
            wr_en = 1'b1;
            if (op == OP_READ) begin
                wr_state = LS_S;
                wr_data  = reply_data;
            end
        end
    end

    assign sn_match     = !reset && (sn_state != LS_I) && (sn_tag == dir_snoop_addr[7:INDEX_W]);
    assign snoop_inv    = sn_match && dir_invalidate;
    assign snoop_fetch  = sn_match && !dir_invalidate && dir_fetch && (sn_state == LS_M);
    assign snoop_wb     = (snoop_inv && sn_state == LS_M) || snoop_fetch;
    assign sn_en        = snoop_inv || snoop_fetch;
    assign sn_new_state = snoop_inv ? LS_I : LS_S;

    // Victim eviction yields the write-back port to a snoop and retries next cycle.
    assign clr_en = (state == ST_WB) && !snoop_wb;
    assign fsm_wb = clr_en && !reset && (lk_state == LS_M);

    assign wb_valid = snoop_wb || fsm_wb;
    assign wb_addr  = snoop_wb ? dir_snoop_addr : (fsm_wb ? {lk_tag, lk_index} : 8'h00);
    assign wb_data  = snoop_wb ? sn_data        : (fsm_wb ? lk_data : 8'h00);

    // An upgrade whose S copy has been (or is being) invalidated becomes a write miss.
    assign race_inv = (op == OP_UPG) && snoop_inv && (dir_snoop_addr == req_addr);
    assign upg_ok   = lk_hit && (lk_state == LS_S) && !race_inv;
    assign eff_op   = (op == OP_UPG && !upg_ok) ? OP_WRITE : op;

    always_comb begin
        msg_out  = 3'b000;
        msg_addr = 8'h00;
        if (state == ST_REQ && !reset) begin
            msg_addr = req_addr;
            case (eff_op)
                OP_READ: msg_out[MSG_READ]  = 1'b1;
                OP_UPG:  msg_out[MSG_INV]   = 1'b1;
                default: msg_out[MSG_WRITE] = 1'b1;
            endcase
        end
    end

    assign cpu_ready = (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            op         <= OP_READ;
            req_addr   <= '0;
            req_wdata  <= '0;
            reply_data <= '0;
            retry      <= 1'b0;
            cpu_done   <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            cpu_done <= 1'b0;
            case (state)
                ST_IDLE: if (cpu_req_valid) begin
                    req_addr  <= cpu_req_addr;
                    req_wdata <= cpu_req_wdata;
                    op        <= cpu_req_write ? OP_WRITE : OP_READ;
                    retry     <= 1'b0;
                    if (lk_hit && (!cpu_req_write || lk_state == LS_M)) begin
                        cpu_done  <= 1'b1;
                        cpu_rdata <= cpu_req_write ? cpu_req_wdata : lk_data;
                    end else if (lk_hit) begin
                        op    <= OP_UPG;
                        state <= ST_REQ;
                    end else if (lk_state == LS_M) begin
                        state <= ST_WB;
                    end else begin
                        state <= ST_REQ;
                    end
                end
                ST_WB: if (!snoop_wb) state <= ST_REQ;
                ST_REQ: begin
                    op    <= eff_op;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (race_inv) begin
                        op    <= OP_WRITE;
                        retry <= 1'b1;
                    end
                    if (dir_reply_valid) begin
                        reply_data <= dir_reply_data;
                        retry      <= 1'b0;
                        state      <= (retry || race_inv) ? ST_REQ : ST_FILL;
                    end
                end
                ST_FILL: begin
                    cpu_done  <= 1'b1;
                    cpu_rdata <= wr_data;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    l1_line_store u_store (
        .clk          (clk),
        .reset        (reset),
        .lk_index     (lk_index),
        .lk_tag       (lk_tag),
        .lk_state     (lk_state),
        .lk_data      (lk_data),
        .wr_en        (wr_en),
        .wr_tag       (cur_tag),
        .wr_state     (wr_state),
        .wr_data      (wr_data),
        .clr_en       (clr_en),
        .sn_index     (dir_snoop_addr[INDEX_W-1:0]),
        .sn_tag       (sn_tag),
        .sn_state     (sn_state),
        .sn_data      (sn_data),
        .sn_en        (sn_en),
        .sn_new_state (sn_new_state)
    );
endmodule
